// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and the transmit FSM states.
package mmio_pkg;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;

   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_BUSY    = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   // STATUS exposes only a 3-bit occupancy, so deeper FIFOs saturate at 7
   function automatic logic [2:0] sat3(input int unsigned n);
      return (n > 7) ? 3'd7 : n[2:0];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL register window
// in front of a TX FIFO and a start/data/stop serializer.
module mmio_uart_tx
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        sel,
   output logic        tx
);
   localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

   tx_state_e       state, state_nxt;
   logic [15:0]     baud_cnt, baud_nxt;
   logic [2:0]      bit_idx, bit_nxt;
   logic [7:0]      shreg, head;
   logic [CW-1:0]   count;
   logic [1:0]      off;
   logic            enable, overflow, busy, baud_end;
   logic            wr_txdata, wr_status, wr_ctrl;
   logic            pop, full, empty;
   logic            unused_bits;

   assign unused_bits = ^{DataAdr[1:0], WriteData[31:8]};

   assign sel       = (DataAdr[31:4] == BASE_ADDR[31:4]);
   assign off       = DataAdr[3:2];
   assign wr_txdata = MemWrite && sel && (off == OFF_TXDATA);
   assign wr_status = MemWrite && sel && (off == OFF_STATUS);
   assign wr_ctrl   = MemWrite && sel && (off == OFF_CTRL);
   assign busy      = (state != IDLE);

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_txdata),
      .pop   (pop),
      .din   (WriteData[7:0]),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      ReadData = '0;
      if (sel) begin
         case (off)
            OFF_STATUS: begin
               ReadData[ST_CNT_LSB +: 3] = sat3(int'(count));
               ReadData[ST_OVF]          = overflow;
               ReadData[ST_BUSY]         = busy;
               ReadData[ST_EMPTY]        = empty;
               ReadData[ST_FULL]         = full;
            end
            OFF_CTRL: ReadData[0] = enable;
            default:  ReadData = '0;
         endcase
      end
   end

   // A push on a full FIFO is only lost when the serializer is not popping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (wr_ctrl) enable <= WriteData[0];
         if (wr_txdata && full && !pop)
            overflow <= 1'b1;
         else if (wr_status && WriteData[ST_OVF])
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= bit_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (pop) shreg <= head;
   end

   assign baud_end = (baud_cnt == BAUD_MAX);

   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_end ? '0 : baud_cnt + 16'd1;
      bit_nxt   = bit_idx;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            baud_nxt = '0;
            if (enable && !empty) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: if (baud_end) state_nxt = DATA;
         DATA: begin
            if (baud_end) begin
               bit_nxt = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            // chain straight into the next frame when more data is queued
            if (baud_end) begin
               if (enable && !empty) begin
                  pop       = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx = 1'b1;
      case (state)
         START:   tx = 1'b0;
         DATA:    tx = shreg[bit_idx];
         default: tx = 1'b1;
      endcase
   end

endmodule
